// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 FFT stage sequencer.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int LOG2N_DEF          = 3;
   localparam int BF_LATENCY_DEF     = 4;
   localparam int MEM_RD_LATENCY_DEF = 1;

endpackage

// File: rtl/fft_valid_delay.sv
// Fixed-depth shift register that carries read strobes/addresses to write-back.
module fft_valid_delay #(
   parameter int DEPTH = 5,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   output logic          q_valid,
   output logic [AW-1:0] q_addr0,
   output logic [AW-1:0] q_addr1
);

   logic [2*AW:0] line [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) line[i] <= '0;
      end else begin
         line[0] <= {valid, addr0, addr1};
         for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
   end

   assign {q_valid, q_addr0, q_addr1} = line[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT address/twiddle sequencer with a drained write pipeline.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2N          = LOG2N_DEF,
   parameter int MEM_RD_LATENCY = MEM_RD_LATENCY_DEF,
   parameter int BF_LATENCY     = BF_LATENCY_DEF,
   localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1,
   localparam int SW = $clog2(LOG2N) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr0,
   output logic [LOG2N-1:0] rd_addr1,
   output logic [KW-1:0]    tw_idx,
   output logic [SW-1:0]    stage,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr0,
   output logic [LOG2N-1:0] wr_addr1
);

   localparam int HALF = (2**LOG2N) / 2;
   localparam int L    = MEM_RD_LATENCY + BF_LATENCY;
   localparam int DW   = (L > 1) ? $clog2(L) : 1;

   state_t           state;
   logic [KW-1:0]    k;
   logic [DW-1:0]    dcnt;

   logic [KW-1:0]    nk;
   logic [SW-1:0]    ns;
   logic [SW-1:0]    nsh;
   logic [LOG2N-1:0] nspan;
   logic [LOG2N-1:0] nlo;
   logic [LOG2N-1:0] n_a0;
   logic [LOG2N-1:0] n_a1;
   logic [KW-1:0]    n_tw;

   // Operands of the butterfly that would be issued next cycle.
   always_comb begin
      nk = '0;
      ns = '0;
      unique case (state)
         RUN: begin
            nk = k + KW'(1);
            ns = stage;
         end
         DRAIN: ns = stage + SW'(1);
         default: ns = '0;
      endcase
      nspan = LOG2N'(1) << ns;
      nlo   = LOG2N'(nk) & (nspan - LOG2N'(1));
      n_a0  = ((LOG2N'(nk) >> ns) << (ns + SW'(1))) + nlo;
      n_a1  = n_a0 + nspan;
      nsh   = SW'(LOG2N - 1) - ns;
      n_tw  = KW'(nlo << nsh);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         stage    <= '0;
         dcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr0 <= '0;
         rd_addr1 <= '0;
         tw_idx   <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               state    <= RUN;
               k        <= '0;
               stage    <= '0;
               busy     <= 1'b1;
               rd_en    <= 1'b1;
               rd_addr0 <= n_a0;
               rd_addr1 <= n_a1;
               tw_idx   <= n_tw;
            end
            RUN: if (k == KW'(HALF - 1)) begin
               state    <= DRAIN;
               dcnt     <= '0;
               rd_en    <= 1'b0;
               rd_addr0 <= '0;
               rd_addr1 <= '0;
               tw_idx   <= '0;
            end else begin
               k        <= nk;
               rd_addr0 <= n_a0;
               rd_addr1 <= n_a1;
               tw_idx   <= n_tw;
            end
            // Next stage reads only once the last write of this one is out.
            DRAIN: if (dcnt == DW'(L - 1)) begin
               if (stage == SW'(LOG2N - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= RUN;
                  stage    <= ns;
                  k        <= '0;
                  rd_en    <= 1'b1;
                  rd_addr0 <= n_a0;
                  rd_addr1 <= n_a1;
                  tw_idx   <= n_tw;
               end
            end else begin
               dcnt <= dcnt + DW'(1);
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   fft_valid_delay #(
      .DEPTH(L),
      .AW   (LOG2N)
   ) u_dly (
      .clk    (clk),
      .rst    (rst),
      .valid  (rd_en),
      .addr0  (rd_addr0),
      .addr1  (rd_addr1),
      .q_valid(wr_en),
      .q_addr0(wr_addr0),
      .q_addr1(wr_addr1)
   );

endmodule
